t_pulse_latch: RTL and testbench
================================

# t_pulse_latch

Single-bit toggle storage element with pulse-latch semantics. Its output `q` inverts once per rising clock edge when toggle enable `t` is high, and holds otherwise. The element behaves exactly like an edge-triggered T flip-flop. It is a leaf cell in the flip-flop library, for use in counters, frequency dividers and parity trackers.

## Interface
Parameters:
- `RESET_VAL`, default 1'b0: value loaded into `q` on reset.

Ports:
- `clk`, input, 1: single clock; all state changes occur on its rising edge only.
- `reset`, input, 1: reset is synchronous and active-high; sampled on the rising edge of `clk`.
- `t`, input, 1: toggle enable, sampled on the rising edge of `clk`.
- `q`, output, 1: stored state, driven directly from the storage register.

## Operation
- At each rising edge of `clk`, in priority order:
  - `reset`=1: `q` <= `RESET_VAL` (0 by default), regardless of `t`.
  - `reset`=0 and `t`=1: `q` <= ~`q`.
  - `reset`=0 and `t`=0: `q` holds.
- Exactly one toggle per edge, however long `t` stays high. A `t` held high for N edges toggles `q` N times; this is not a level-transparent latch.
- Pulses on `t` that start and end between two rising edges have no effect.
- `reset` and `t` both high: reset wins and `q` = `RESET_VAL`. The next edge with `t`=1 toggles from `RESET_VAL`.
- Reset mid-sequence: toggle history is discarded and `q` returns to `RESET_VAL` at that edge.
- Before the first reset edge, `q` is undefined (X in simulation). No `initial` value is given, so the bench must detect a missing reset.

## Timing
- Latency: `q` reflects an edge's decision immediately after that rising edge, i.e. 1-cycle latency from sampling `t`.
- No combinational path from `t` or `reset` to `q`.
- Setup and hold are relative to the rising edge of `clk` only. The implementation must not generate an internal pulse clock or gate `clk`; the "pulse" window is modeled as the rising-edge sample.
- Maximum toggle rate: `q` toggles every cycle when `t`=1 continuously, giving `clk`/2 on `q`.

## Structure
- Shared package `flop_pkg`: constant `T_PULSE_RESET_DEFAULT` = 1'b0, used as the default for `RESET_VAL`.
- One always block on the rising edge of `clk` with a synchronous reset branch; no sub-module is needed.
- If a standalone toggle-decision helper is wanted for reuse by multi-bit counters, name it `t_toggle_cell`: combinational `next_q = t ? ~q : q`.
- Optional assertions (simulation only), each checked one edge after the stated condition:
  - After a `reset` edge: `q` == `RESET_VAL`.
  - After `!reset && t`: `q` == previous ~`q`.
  - After `!reset && !t`: `q` is stable.

## Test plan
The bench uses a 10 ns `clk` with rising edges at 5, 15, 25 … ns.
- Reset: `reset`=1, `t`=0 through the 5 ns edge, release at 12 ns -> `q`=0 after the 5 ns edge.
- Toggle train: `t` pulses high for one cycle with one cycle low between pulses (t=1 at 12–22, 32–42, 52–62 ns) -> `q`=1 after 15 ns, 1 at 25 ns, 0 after 35 ns, 0 at 45 ns, 1 after 55 ns, final `q`=1.
- Continuous toggle: `t`=1 for 4 consecutive edges from `q`=0 -> `q` sequence 1,0,1,0.
- Sub-cycle glitch: `t` high only from 16 to 19 ns (no edge inside) -> `q` unchanged.
- Reset priority: `q`=1, then `reset`=1 and `t`=1 at the same edge -> `q`=0; release reset with `t`=1 -> `q`=1 on the next edge.
- Parameter: `RESET_VAL`=1, reset asserted -> `q`=1; one `t` edge -> `q`=0.

Source files
------------

// File: rtl/flop_pkg.sv
// Shared constants and helpers for the flip-flop cell library.
package flop_pkg;

   localparam logic T_PULSE_RESET_DEFAULT = 1'b0;

   // Toggle decision shared by single-bit cells and multi-bit counters.
   function automatic logic toggle_next(input logic t, input logic q);
      return t ? ~q : q;
   endfunction

endpackage

// File: rtl/t_toggle_cell.sv
// Combinational toggle decision: next_q = t ? ~q : q.
import flop_pkg::*;

module t_toggle_cell (
   input  logic t,
   input  logic q,
   output logic next_q
);

   always_comb begin
      next_q = toggle_next(t, q);
   end

endmodule

// File: rtl/t_pulse_latch.sv
// Edge-triggered T storage cell; q toggles once per rising clk edge while t is high.
import flop_pkg::*;

module t_pulse_latch #(
   parameter logic RESET_VAL = T_PULSE_RESET_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   logic next_q;

   t_toggle_cell u_toggle (
      .t      (t),
      .q      (q),
      .next_q (next_q)
   );

   // The "pulse" window is the rising-edge sample; clk is never gated.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VAL;
      end else begin
         q <= next_q;
      end
   end

endmodule

// File: tb/tb_t_pulse_latch.sv
// Directed bench for t_pulse_latch: default and RESET_VAL=1 instances share stimulus.
module tb_t_pulse_latch;

   logic clk;
   logic reset;
   logic t;
   logic q0;
   logic q1;

   int unsigned total;
   int unsigned bad;

   // Each entry: {reset, t, expected q (default), expected q (RESET_VAL=1)}
   logic [3:0] vec [0:19];

   t_pulse_latch u_dut0 (
      .clk   (clk),
      .reset (reset),
      .t     (t),
      .q     (q0)
   );

   t_pulse_latch #(.RESET_VAL(1'b1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .t     (t),
      .q     (q1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   // Inputs change 7 ns after an edge, outputs are sampled 1 ns after the next edge.
   task automatic run_vec(input int unsigned idx);
      logic [3:0] v;
      v = vec[idx];
      reset = v[3];
      t     = v[2];
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q_def", idx), q0, v[1]);
      check($sformatf("v%0d_q_rv1", idx), q1, v[0]);
      #6;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      vec[0]  = 4'b10_01; // reset through the 5 ns edge
      vec[1]  = 4'b01_10; // toggle train
      vec[2]  = 4'b00_10;
      vec[3]  = 4'b01_01;
      vec[4]  = 4'b00_01;
      vec[5]  = 4'b01_10;
      vec[6]  = 4'b00_10;
      vec[7]  = 4'b01_01; // back to 0 before continuous run
      vec[8]  = 4'b01_10; // continuous toggle: 1,0,1,0
      vec[9]  = 4'b01_01;
      vec[10] = 4'b01_10;
      vec[11] = 4'b01_01;
      vec[12] = 4'b00_01; // hold before glitch
      vec[13] = 4'b01_10; // q=1 ahead of reset priority
      vec[14] = 4'b11_01; // reset and t together: reset wins
      vec[15] = 4'b01_10; // toggles from reset value
      vec[16] = 4'b01_01;
      vec[17] = 4'b10_01; // mid-sequence reset
      vec[18] = 4'b01_10;
      vec[19] = 4'b00_10;

      reset = 1'b1;
      t     = 1'b0;
      // First vector starts at time 0; its edge is at 5 ns.
      for (int unsigned i = 0; i <= 12; i++) begin
         run_vec(i);
      end

      // Sub-cycle glitch: t high strictly between two rising edges.
      @(posedge clk);
      #1 t = 1'b1;
      #3 t = 1'b0;
      @(posedge clk);
      #1;
      check("glitch_q_def", q0, 1'b0);
      check("glitch_q_rv1", q1, 1'b1);
      #6;

      for (int unsigned i = 13; i <= 19; i++) begin
         run_vec(i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
